// File: rtl/antilog2_iter.sv
// rtl/antilog2_iter.sv - iterative base-2 antilog, 2^f in 1.15 (ANTILOG2_ROUND_EN selects round-to-nearest)
module antilog2_iter #(
  parameter int IN_WIDTH  = 7,
  parameter int MAN_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [IN_WIDTH-1:0]  frac_value,
  output logic                 in_ready,
  output logic [MAN_WIDTH-1:0] output_value,
  output logic                 out_valid
);

  localparam int CNT_W = (IN_WIDTH > 1) ? $clog2(IN_WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(IN_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [15:0]        acc;
  logic [15:0]        out_reg;
  logic [IN_WIDTH-1:0] f_reg;
  logic [CNT_W-1:0]   count;

  logic [3:0]         k_idx;
  logic [15:0]        c_k;
  logic [31:0]        prod;
  logic [15:0]        acc_mul;
  logic [15:0]        acc_next;
  logic               unused_low_bits;

  // C[k] = floor(2^(2^-k) * 32768); k=1 is the weight of the fraction MSB
  function automatic logic [15:0] c_rom(input logic [3:0] k);
    case (k)
      4'd1:    c_rom = 16'hB504;
      4'd2:    c_rom = 16'h9837;
      4'd3:    c_rom = 16'h8B95;
      4'd4:    c_rom = 16'h85AA;
      4'd5:    c_rom = 16'h82CD;
      4'd6:    c_rom = 16'h8164;
      4'd7:    c_rom = 16'h80B1;
      default: c_rom = 16'h8000;
    endcase
  endfunction

  assign k_idx = 4'(IN_WIDTH) - 4'(count);
  assign c_k   = c_rom(k_idx);
  assign prod  = 32'(acc) * 32'(c_k);

`ifdef ANTILOG2_ROUND_EN
  logic [32:0] prod_rnd;
  assign prod_rnd        = {1'b0, prod} + 33'h0000_4000;
  assign acc_mul         = (prod_rnd[32:31] != 2'b00) ? 16'hFFFF : prod_rnd[30:15];
  assign unused_low_bits = ^prod_rnd[14:0];
`else
  // P[31] cannot be set for operands in [1,2); saturation only guards against it
  assign acc_mul         = prod[31] ? 16'hFFFF : prod[30:15];
  assign unused_low_bits = ^prod[14:0];
`endif

  assign acc_next = f_reg[count] ? acc_mul : acc;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode; illegal encoding recovers to IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = EVAL;
      EVAL:    if (count == '0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: load on accept, one fraction bit per EVAL cycle, MSB first
  always_ff @(posedge clk) begin
    if (rst) begin
      acc     <= 16'h0000;
      f_reg   <= '0;
      count   <= CNT_TOP;
      out_reg <= 16'h0000;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            acc   <= 16'h8000;
            f_reg <= frac_value;
            count <= CNT_TOP;
          end
        end
        EVAL: begin
          acc <= acc_next;
          if (count == '0) out_reg <= acc_next;
          else             count   <= count - 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign in_ready     = (state == IDLE);
  assign out_valid    = (state == DONE);
  assign output_value = MAN_WIDTH'(out_reg);

endmodule

// File: tb/tb_antilog2_iter.sv
// tb/tb_antilog2_iter.sv - self-checking bench for antilog2_iter (honours ANTILOG2_ROUND_EN)
module tb_antilog2_iter;

  localparam int IW = 7;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic [IW-1:0] frac_value;
  logic          in_ready;
  logic [15:0]   output_value;
  logic          out_valid;

  int checks = 0;
  int errors = 0;

  antilog2_iter #(.IN_WIDTH(IW), .MAN_WIDTH(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .frac_value   (frac_value),
    .in_ready     (in_ready),
    .output_value (output_value),
    .out_valid    (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [IW-1:0] f;
    logic [15:0]   exp;
  } vec_t;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: product of 2^(2^-k) factors for each set bit, quantised after each multiply
  function automatic logic [15:0] model(input logic [IW-1:0] f);
    longint c_tab [1:7];
    longint acc;
    longint p;
    c_tab[1] = 46340; c_tab[2] = 38967; c_tab[3] = 35733; c_tab[4] = 34218;
    c_tab[5] = 33485; c_tab[6] = 33124; c_tab[7] = 32945;
    acc = 32768;
    for (int k = 1; k <= IW; k++) begin
      if (f[IW-k]) begin
        p = acc * c_tab[k];
`ifdef ANTILOG2_ROUND_EN
        acc = (p + 16384) / 32768;
`else
        acc = p / 32768;
`endif
        if (acc > 65535) acc = 65535;
      end
    end
    return acc[15:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request and check latency, result, and single-cycle pulse
  task automatic run_op(input logic [IW-1:0] f, input logic [15:0] exp, input string name);
    int cyc;
    cyc = 0;
    in_valid   = 1'b1;
    frac_value = f;
    tick();
    in_valid = 1'b0;
    check({name, "_accepted"}, in_ready, 0);
    for (int i = 1; i <= 20; i++) begin
      if (out_valid) begin
        cyc = i - 1;
        break;
      end
      tick();
    end
    if (cyc == 0) begin
      check({name, "_timeout"}, 0, 1);
    end else begin
      check({name, "_latency"}, cyc + 1, IW + 1);
      check({name, "_value"}, output_value, exp);
      tick();
      check({name, "_pulse_end"}, out_valid, 0);
      check({name, "_ready_after"}, in_ready, 1);
      check({name, "_hold"}, output_value, exp);
    end
  endtask

  initial begin
    vec_t vecs [$];
    vec_t v;
    int   cyc;
    logic [IW-1:0] r;

    rst = 1'b1;
    in_valid = 1'b0;
    frac_value = '0;
    tick();
    tick();
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      check("reset_value", output_value, 16'h0000);
      check("reset_out_valid", out_valid, 0);
      check("reset_in_ready", in_ready, 1);
      tick();
    end

    v.f = 7'h00; v.exp = 16'h8000; vecs.push_back(v);
    v.f = 7'h40; v.exp = 16'hB504; vecs.push_back(v);
    v.f = 7'h20; v.exp = 16'h9837; vecs.push_back(v);
    v.f = 7'h01; v.exp = 16'h80B1; vecs.push_back(v);
`ifdef ANTILOG2_ROUND_EN
    v.f = 7'h60; v.exp = 16'hD743; vecs.push_back(v);
`else
    v.f = 7'h60; v.exp = 16'hD742; vecs.push_back(v);
`endif
    foreach (vecs[i]) run_op(vecs[i].f, vecs[i].exp, $sformatf("vec%0d", i));

    for (int i = 0; i < 20; i++) begin
      r = IW'($urandom_range(0, (1 << IW) - 1));
      run_op(r, model(r), $sformatf("rand_f%0h", r));
    end

    // Busy: in_valid held through EVAL and DONE with a second operand
    in_valid = 1'b1;
    frac_value = 7'h40;
    tick();
    frac_value = 7'h20;
    cyc = 0;
    for (int i = 1; i <= 20; i++) begin
      if (out_valid) begin cyc = i; break; end
      check("busy_in_ready_low", in_ready, 0);
      tick();
    end
    check("busy_first_latency", cyc, IW + 1);
    check("busy_first_value", output_value, 16'hB504);
    tick();
    check("busy_idle_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    check("busy_second_accepted", in_ready, 0);
    cyc = 0;
    for (int i = 1; i <= 20; i++) begin
      if (out_valid) begin cyc = i; break; end
      check("busy_hold_prev", output_value, 16'hB504);
      tick();
    end
    check("busy_second_latency", cyc, IW + 1);
    check("busy_second_value", output_value, 16'h9837);
    tick();

    // Reset asserted mid-EVAL discards the operation
    in_valid = 1'b1;
    frac_value = 7'h40;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_value", output_value, 16'h0000);
    check("midrst_in_ready", in_ready, 1);
    for (int i = 0; i < IW + 3; i++) begin
      check("midrst_no_pulse", out_valid, 0);
      tick();
    end
    run_op(7'h40, 16'hB504, "after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
